// File: rtl/multicycle_control.sv
// Multicycle control sequencer for the X9 core.
// Steps each instruction through FETCH, DECODE, EXEC, (MEM), WB and drives the
// datapath control strobes from the opcode latched in DECODE. Counts retired
// instructions (saturating) and supports a halt opcode.
//
// Ports:
//   Clk, Reset    - clock, synchronous active-high reset
//   Start         - leave IDLE/HALT and begin fetching (clears InstCount from HALT)
//   instr         - opcode from IR, sampled in DECODE only
//   MemAck        - data memory handshake, sampled in MEM only
//   IRWrite, PCWrite, BranchInst, MemRead, MemWrite, MemtoReg, RegWrite - strobes
//   ALUSrc        - 1: register operand, 0: immediate
//   InstType      - 00 normal, 10 movr, 11 movi
//   ALUOp         - ALU operation (4-bit codes zero-extended)
//   IllegalOp     - one-cycle pulse in EXEC for an unmapped opcode
//   Done          - high while halted
//   InstCount     - retired instruction count, saturating
module multicycle_control #(
  parameter int unsigned opwidth   = 4,
  parameter int unsigned mcodebits = 5,
  parameter int unsigned CNTW      = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [mcodebits-1:0] instr,
  input  logic                 MemAck,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 BranchInst,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 ALUSrc,
  output logic [1:0]           InstType,
  output logic [opwidth-1:0]   ALUOp,
  output logic                 IllegalOp,
  output logic                 Done,
  output logic [CNTW-1:0]      InstCount
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt
  } state_e;

  localparam logic [mcodebits-1:0] HaltOp = mcodebits'(6);

  state_e               state_q, state_d;
  logic [mcodebits-1:0] op_q;
  logic [CNTW-1:0]      count_q, count_d;

  // Opcode decode from the latched opcode.
  logic       is_mov, is_low;
  logic [3:0] low;
  logic       is_lb, is_sb, is_bt, is_cmp;
  logic [3:0] dec_alu;
  logic       dec_src, dec_m2r, dec_ill;
  logic [1:0] dec_type;

  assign is_mov = op_q[mcodebits-1];
  // Codes 0-15 need every bit above bit 3 clear; for 5-bit opcodes this is just !is_mov.
  assign is_low = (op_q >> 4) == '0;
  assign low    = op_q[3:0];
  assign is_lb  = is_low && (low == 4'd3);
  assign is_sb  = is_low && (low == 4'd4);
  assign is_bt  = is_low && (low == 4'd5);
  assign is_cmp = is_low && ((low == 4'd13) || (low == 4'd14));

  always_comb begin
    dec_alu  = 4'hF;
    dec_src  = 1'b1;
    dec_m2r  = 1'b0;
    dec_ill  = 1'b0;
    dec_type = 2'b00;
    if (is_mov) begin
      dec_type = {1'b1, op_q[mcodebits-2]};
      dec_alu  = op_q[mcodebits-2] ? 4'b0110 : 4'b0101;
    end else if (!is_low) begin
      dec_ill = 1'b1;
    end else begin
      // Most mapped codes use their own value as the ALU op; bt shares 1111 with rxor.
      dec_alu = (low == 4'd5) ? 4'hF : low;
      dec_src = (low != 4'd2);
      dec_m2r = (low == 4'd3);
      // 6 is the halt opcode and never reaches EXEC; treat it as unmapped anyway.
      dec_ill = (low == 4'd6);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StHalt: if (Start) state_d = StFetch;
      StFetch:        state_d = StDecode;
      StDecode:       state_d = (instr == HaltOp) ? StHalt : StExec;
      StExec: begin
        if (is_bt || is_cmp)     state_d = StFetch;
        else if (is_lb || is_sb) state_d = StMem;
        else                     state_d = StWb;
      end
      StMem:          if (MemAck) state_d = is_sb ? StFetch : StWb;
      StWb:           state_d = StFetch;
      default:        state_d = StIdle;
    endcase
  end

  // Control outputs decoded from the state register and latched opcode.
  logic in_dp;
  assign in_dp = (state_q == StExec) || (state_q == StMem) || (state_q == StWb);

  always_comb begin
    IRWrite    = (state_q == StFetch);
    BranchInst = (state_q == StExec) && is_bt;
    MemRead    = (state_q == StMem) && is_lb;
    MemWrite   = (state_q == StMem) && is_sb;
    RegWrite   = (state_q == StWb) && !dec_ill;
    IllegalOp  = (state_q == StExec) && dec_ill;
    Done       = (state_q == StHalt);
    // sb retires in the ack cycle itself, so this one strobe follows MemAck.
    PCWrite    = ((state_q == StExec) && (is_bt || is_cmp)) ||
                 ((state_q == StMem) && is_sb && MemAck) ||
                 (state_q == StWb);
    ALUOp      = in_dp ? opwidth'(dec_alu) : '1;
    ALUSrc     = in_dp ? dec_src : 1'b1;
    InstType   = in_dp ? dec_type : 2'b00;
    MemtoReg   = in_dp && dec_m2r;
  end

  always_comb begin
    count_d = count_q;
    if ((state_q == StHalt) && Start) begin
      count_d = '0;
    end else if (PCWrite && (count_q != '1)) begin
      count_d = count_q + CNTW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) op_q <= instr;
      count_q <= count_d;
    end
  end

  assign InstCount = count_q;

endmodule
